// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: valid/ready stream FIFO built around an external dual-port
// block RAM (one write port, one registered read port with 1-cycle latency).
// A 2-entry output buffer absorbs the read latency so dequeue runs at
// 1 word/cycle. Capacity is 2**ADDR_WIDTH + 2 words.
// Optional: define BRAM_FIFO_CTRL_BYPASS_EN to route words that arrive while
// the FIFO is drained of RAM and in-flight data straight into the output
// buffer (empty-FIFO latency 1 cycle instead of 3).
module bram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]        ram_cnt;
  logic                       inflight;
  logic [1:0][DATA_WIDTH-1:0] obuf;       // [0] is the head
  logic [1:0]                 obuf_cnt;
  logic [1:0]                 occ;        // obuf entries + read in flight, never above 2
  logic                       enq, deq, wr, issue, push, byp;
  logic [DATA_WIDTH-1:0]      push_data;

  // in_ready depends on registers only, so no out_ready -> in_ready path
  assign in_ready  = (ram_cnt != DEPTH);
  assign out_valid = (obuf_cnt != 2'd0);
  assign out_data  = obuf[0];

  assign occ = obuf_cnt + {1'b0, inflight};
  assign enq = in_valid & in_ready & ~RST;
  assign deq = out_valid & out_ready;

`ifdef BRAM_FIFO_CTRL_BYPASS_EN
  // nothing older sits in RAM or in flight, so going straight to obuf keeps order
  assign byp = enq & (ram_cnt == '0) & ~inflight & ((obuf_cnt != 2'd2) | deq);
`else
  assign byp = 1'b0;
`endif

  assign wr = enq & ~byp;
  // refill obuf while there is room for the returning word, counting a pop this cycle
  assign issue = ~RST & (ram_cnt != '0) & ((occ < 2'd2) | ((occ == 2'd2) & deq));

  // inflight and bypass are mutually exclusive (bypass needs inflight==0)
  assign push      = inflight | byp;
  assign push_data = byp ? in_data : ram_do;

  assign ram_we      = wr;
  assign ram_wr_addr = wr_ptr;
  assign ram_di      = in_data;
  assign ram_re      = issue;
  assign ram_rd_addr = rd_ptr;

  assign count = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(inflight)
               + (ADDR_WIDTH+2)'(obuf_cnt);

  // pointers, occupancy counters and the in-flight flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      obuf_cnt <= 2'd0;
    end else begin
      if (wr)    wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, issue})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
      inflight <= issue;
      case ({push, deq})
        2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
        2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
        default: obuf_cnt <= obuf_cnt;
      endcase
    end
  end

  // output buffer data: pop shifts [1] to head, push lands at the tail
  always_ff @(posedge CLK) begin
    if (deq) begin
      obuf[0] <= (push && obuf_cnt == 2'd1) ? push_data : obuf[1];
      if (push) obuf[1] <= push_data;
    end else if (push) begin
      if (obuf_cnt == 2'd0) obuf[0] <= push_data;
      else                  obuf[1] <= push_data;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl (ADDR_WIDTH=2, DATA_WIDTH=8) with a
// behavioural RAM, a reference queue for data order and a same-address
// read/write monitor. Honours BRAM_FIFO_CTRL_BYPASS_EN for expected latency.
module tb_bram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
`ifdef BRAM_FIFO_CTRL_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, ram_we, ram_re;
  logic [DW-1:0] out_data, ram_di, ram_do;
  logic [AW+1:0] count;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;

  logic [DW-1:0] mem [4];
  logic [DW-1:0] q[$];
  int n_chk = 0, n_err = 0, n_coll = 0;

  bram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_di(ram_di),
    .ram_re(ram_re), .ram_rd_addr(ram_rd_addr), .ram_do(ram_do)
  );

  always #5 CLK = ~CLK;

  // behavioural dual-port RAM, registered read
  always @(posedge CLK) begin
    if (ram_we) mem[ram_wr_addr] <= ram_di;
    if (ram_re) ram_do <= mem[ram_rd_addr];
  end

  // same-address read/write monitor
  always @(negedge CLK) begin
    if (ram_we && ram_re && ram_wr_addr == ram_rd_addr) n_coll++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // settle inputs, log handshakes against the reference queue, advance a cycle
  task automatic tick();
    #1;
    if (!RST) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("deq_unexpected", 32'd1, 32'd0);
        else               chk("deq_data", out_data, q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; in_valid = 1'b1; in_data = 8'hEE; out_ready = 1'b1;
    repeat (2) begin
      #1;
      chk("rst_we", ram_we, 0);
      chk("rst_re", ram_re, 0);
      @(posedge CLK); #1;
    end
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q.delete();
    chk("rst_ovalid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_iready", in_ready, 1);
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40 && count != 0; i++) tick();
    chk("drain_count", count, 0);
    chk("drain_q", q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    do_reset();

    // single word latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    chk("t0_iready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= LAT; c++) begin
      chk("lat_ovalid", out_valid, (c == LAT) ? 1 : 0);
      if (c < LAT) tick();
    end
    chk("lat_data", out_data, 8'hA5);
    tick();
    chk("single_count", count, 0);
    chk("single_q", q.size(), 0);

    // fill to capacity 6 with consumer stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = i[DW-1:0];
      chk("fill_iready", in_ready, 1);
      tick();
    end
    in_valid = 1'b1; in_data = 8'h07;
    chk("full_iready", in_ready, 0);
    chk("full_count", count, 6);
    chk("full_head", out_data, 8'h01);
    tick();
    chk("no_7th_count", count, 6);
    chk("no_7th_iready", in_ready, 0);
    drain();

    // streaming: no gaps after initial latency, steady occupancy equals LAT
    do_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = DW'(8'h40 + c);
      if (c >= LAT) begin
        chk("strm_ovalid", out_valid, 1);
        chk("strm_count", count, LAT);
      end
      tick();
    end

    // reset mid-stream with a read in flight; stale ram_do must not surface
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_ovalid", out_valid, 0);
      chk("post_rst_count", count, 0);
      tick();
    end

    // wrap-around: 3 fill/drain rounds of 4 words, 0x10..0x1B
    for (int r = 0; r < 3; r++) begin
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'b1; in_data = DW'(8'h10 + 4*r + i);
        tick();
      end
      in_valid = 1'b0;
      chk("wrap_count", count, 4);
      drain();
    end

    // random backpressure against the reference queue
    for (int c = 0; c < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = DW'($urandom);
      tick();
    end
    drain();
    chk("no_collision", n_coll, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Synchronous FIFO controller that owns a dual-port block RAM (one write port, one registered read port with 1-cycle read latency) and turns it into a valid/ready stream FIFO.
- Generates the RAM write and read address and enable signals, and absorbs the 1-cycle read latency in a 2-entry output buffer, so a streaming dequeue sustains 1 word/cycle.
- Sits between a producer stream and a consumer stream, for example in command or response queues.

Parameters:
- ADDR_WIDTH, 4, RAM address width; RAM depth is 2**ADDR_WIDTH, total capacity is 2**ADDR_WIDTH+2.
- DATA_WIDTH, 32, word width.

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts a word; enqueue = in_valid & in_ready.
- in_data  in  DATA_WIDTH  word to enqueue.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer takes the word; dequeue = out_valid & out_ready.
- out_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+2  total words held (RAM + in-flight read + output buffer).
- ram_we  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_WIDTH  RAM write address.
- ram_di  out  DATA_WIDTH  RAM write data; equals in_data.
- ram_re  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_WIDTH  RAM read address.
- ram_do  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re.

Behaviour:
- State:
  - wr_ptr and rd_ptr: ADDR_WIDTH bits each, wrap modulo 2**ADDR_WIDTH.
  - ram_cnt: 0..2**ADDR_WIDTH.
  - inflight: 1 bit.
  - obuf: 2 entries, obuf_cnt 0..2.
- Reset (RST=1 at posedge) clears all state. The following cycle:
  - out_valid=0, count=0, in_ready=1.
  - ram_we=0 and ram_re=0 while RST is high.
- in_ready = (ram_cnt != 2**ADDR_WIDTH). Decoded from registers only; no combinational path from out_ready.
- Enqueue:
  - ram_we = enqueue; ram_wr_addr = wr_ptr.
  - On enqueue: wr_ptr+1, ram_cnt+1.
- Read issue:
  - Issue when ram_cnt != 0 and (obuf_cnt + inflight) < 2, or when (obuf_cnt + inflight) == 2 and a dequeue happens this cycle.
  - ram_re = issue; ram_rd_addr = rd_ptr.
  - On issue: rd_ptr+1, ram_cnt-1, inflight set for the next cycle.
- Read return: when inflight=1, ram_do is pushed into obuf at the tail. inflight clears unless a new read issues in the same cycle.
- Output:
  - out_valid = (obuf_cnt != 0); out_data = obuf head.
  - A dequeue pops the head; the second entry shifts to the head.
  - A simultaneous push and pop are both honoured.
- Simultaneous enqueue and issue: ram_cnt is unchanged. Issue uses the registered ram_cnt, so a word written in cycle T is readable no earlier than cycle T+1.
- Collision invariant: ram_re and ram_we never target the same address in one cycle. A read needs ram_cnt>0 and a write needs ram_cnt<depth, so rd_ptr==wr_ptr cannot occur with both enables set. The RAM returns X on a same-address read/write, so the bench must assert this invariant.
- Latency without bypass: an enqueue into an empty FIFO in cycle T gives out_valid in cycle T+3.
- Throughput: with the FIFO full, out_ready held high, and in_valid held high, one word per cycle both ways.
- count = ram_cnt + inflight + obuf_cnt, updated every cycle.
- Reset mid-operation: contents are discarded. ram_do arriving the cycle after reset is ignored (inflight already cleared).

Optional Feature:
- Macro: BRAM_FIFO_CTRL_BYPASS_EN.
- Defined:
  - Bypass condition: an enqueue when ram_cnt==0, inflight==0, and (obuf_cnt<2 or a dequeue this cycle).
  - On bypass, in_data is written straight into obuf, ram_we stays 0, and wr_ptr is unchanged.
  - Empty-FIFO latency becomes T+1; FIFO order is preserved.
- Undefined: every enqueue goes through the RAM; latency is T+3.

Test Plan:
- Single word, ADDR_WIDTH=2, DATA_WIDTH=8. After reset, enqueue 0xA5 at cycle 0 with out_ready=1 -> out_valid first high at cycle 3 (cycle 1 with bypass), out_data=0xA5, count returns to 0.
- Fill: out_ready=0, enqueue 0x01..0x06 -> in_ready drops after the 6th accept, count=6, out_data=0x01; a 7th word is not accepted.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with an incrementing pattern -> output is the same sequence, no gaps after the initial latency, count stable.
- Backpressure: random out_ready and in_valid over 1000 cycles against a reference queue -> data order matches, and the RAM collision invariant is never violated.
- Wrap-around: 3 fill/drain cycles of 4 words -> pointers wrap, and data 0x10..0x1B comes out in order.
- Reset mid-stream: assert RST while inflight=1 and obuf_cnt=2 -> next cycle out_valid=0, count=0, in_ready=1; the stale ram_do never appears on out_data.
